tff_sr_reg_bank: RTL



---
 rtl/tff_sr_reg_bank_if.sv | 24 ++
 rtl/tff_sr_reg_bank.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/tff_sr_reg_bank_if.sv
// Command handshake for the SR-on-T flip-flop bank: per-bit set/reset requests
// qualified by valid/ready.
interface tff_sr_reg_bank_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] r_in;

    modport master (
        output cmd_valid,
        output s_in,
        output r_in,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  s_in,
        input  r_in,
        output cmd_ready
    );
endinterface

// File: rtl/tff_sr_reg_bank.sv
// WIDTH-bit SR flip-flop bank built on a T flip-flop core, with illegal S=R=1
// hold, a sticky conflict flag and saturating toggle/conflict statistics.
module tff_sr_reg_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    tff_sr_reg_bank_if.slave     cmd_if,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     t_vec,
    output logic                 conflict_err,
    output logic [CNT_W-1:0]     toggle_cnt,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int unsigned POP_W = $clog2(WIDTH + 1);
    // Sum is wide enough that toggle_cnt + popcount can never wrap
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] t_vec_q, t_vec_d;
    logic             conflict_err_q, conflict_err_d;
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic             accept;
    logic             apply;
    logic [WIDTH-1:0] conflict_vec;
    logic [WIDTH-1:0] toggle_vec;
    logic [POP_W-1:0] toggle_pop;
    logic [SUM_W-1:0] toggle_sum;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_if.cmd_valid) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready is decoded from state alone
    always_comb begin
        cmd_if.cmd_ready = 1'b0;
        accept           = 1'b0;
        apply            = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_if.cmd_ready = 1'b1;
                accept           = cmd_if.cmd_valid;
            end
            APPLY:   apply = 1'b1;
            default: ;
        endcase
    end

    // SR-to-T conversion; conflicting bits never toggle
    always_comb begin
        conflict_vec = s_q & r_q;
        toggle_vec   = ~conflict_vec & ((s_q & ~q_q) | (r_q & q_q));
        toggle_pop   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            toggle_pop = toggle_pop + POP_W'(toggle_vec[i]);
        end
        toggle_sum = SUM_W'(toggle_cnt_q) + SUM_W'(toggle_pop);
    end

    // Datapath next-state
    always_comb begin
        s_d            = s_q;
        r_d            = r_q;
        q_d            = q_q;
        t_vec_d        = t_vec_q;
        toggle_cnt_d   = toggle_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        conflict_err_d = err_clr ? 1'b0 : conflict_err_q;

        if (accept) begin
            s_d = cmd_if.s_in;
            r_d = cmd_if.r_in;
        end

        if (apply) begin
            q_d          = q_q ^ toggle_vec;
            t_vec_d      = toggle_vec;
            toggle_cnt_d = (toggle_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(toggle_sum);
            // A conflict on the apply edge wins over err_clr
            if (|conflict_vec) begin
                conflict_err_d = 1'b1;
                if (conflict_cnt_q != CNT_MAX) begin
                    conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q            <= '0;
            r_q            <= '0;
            q_q            <= '0;
            t_vec_q        <= '0;
            conflict_err_q <= 1'b0;
            toggle_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            s_q            <= s_d;
            r_q            <= r_d;
            q_q            <= q_d;
            t_vec_q        <= t_vec_d;
            conflict_err_q <= conflict_err_d;
            toggle_cnt_q   <= toggle_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign q            = q_q;
    assign t_vec        = t_vec_q;
    assign conflict_err = conflict_err_q;
    assign toggle_cnt   = toggle_cnt_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
